// File: rtl/str_pkg.sv
// Shared types and constants for the packet-aware stream arbiter.
package str_pkg;

    localparam int VW_DEFAULT = 32;

    typedef enum logic [0:0] {
        ARB,
        PKT
    } arb_state_e;

endpackage

// File: rtl/str_rr_pick.sv
// Combinational round-robin picker: first requester searching upward from ptr+1, wrapping at N.
module str_rr_pick #(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          gnt_vld,
    output logic [SW-1:0] gnt_idx
);

    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        // Walk from the farthest offset down so the nearest requester after ptr wins last.
        for (int off = N; off >= 1; off--) begin
            idx = (int'(ptr) + off) % N;
            if (req[SW'(idx)]) begin
                gnt_vld = 1'b1;
                gnt_idx = SW'(idx);
            end
        end
    end

endmodule

// File: rtl/str_arb.sv
// N-input stream arbiter: round-robin between packets, packets never interleaved,
// single registered output entry with full throughput.
module str_arb
    import str_pkg::*;
#(
    parameter int VW = VW_DEFAULT,
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    s_tvalid,
    output logic [N-1:0]    s_tready,
    input  logic [N-1:0]    s_tlast,
    input  logic [N*VW-1:0] s_tvalue,
    output logic            m_tvalid,
    input  logic            m_tready,
    output logic            m_tlast,
    output logic [VW-1:0]   m_tvalue,
    output logic [SW-1:0]   m_tsel
);

    arb_state_e    state_q, state_d;
    logic [SW-1:0] owner_q, owner_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic          rr_vld;
    logic [SW-1:0] rr_idx;
    logic          gnt_vld;
    logic [SW-1:0] gnt_idx;
    logic          free;
    logic          accept;
    logic          acc_last;
    logic [VW-1:0] acc_value;

    str_rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .req     (s_tvalid),
        .ptr     (ptr_q),
        .gnt_vld (rr_vld),
        .gnt_idx (rr_idx)
    );

    assign free      = !m_tvalid || m_tready;
    assign accept    = gnt_vld && free && !rst && s_tvalid[gnt_idx];
    assign acc_last  = s_tlast[gnt_idx];
    assign acc_value = s_tvalue[int'(gnt_idx)*VW +: VW];

    // State register: FSM, packet owner and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB;
            owner_q <= '0;
            ptr_q   <= SW'(N - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: only accepted beats move the FSM or the pointer.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (accept) begin
            if (acc_last) begin
                state_d = ARB;
                ptr_d   = gnt_idx;
            end else begin
                state_d = PKT;
                owner_d = gnt_idx;
            end
        end
    end

    // Outputs: grant selection and per-source ready.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        s_tready = '0;
        case (state_q)
            ARB: begin
                gnt_vld = rr_vld;
                gnt_idx = rr_idx;
            end
            PKT: begin
                gnt_vld = 1'b1;
                gnt_idx = owner_q;
            end
        endcase
        if (gnt_vld && free && !rst) begin
            s_tready[gnt_idx] = 1'b1;
        end
    end

    // Output entry: a load wins over a drain so back-to-back beats leave no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tvalue <= '0;
            m_tsel   <= '0;
        end else if (accept) begin
            m_tvalid <= 1'b1;
            m_tlast  <= acc_last;
            m_tvalue <= acc_value;
            m_tsel   <= gnt_idx;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_str_arb.sv
// Self-checking bench for str_arb: directed scenarios plus randomized scoreboard traffic.
module tb_str_arb;

    localparam int VW = 32;
    localparam int N  = 4;
    localparam int SW = 2;
    localparam int EW = SW + 1 + VW;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [N-1:0]    s_tlast;
    logic [N*VW-1:0] s_tvalue;
    logic            m_tvalid;
    logic            m_tready;
    logic            m_tlast;
    logic [VW-1:0]   m_tvalue;
    logic [SW-1:0]   m_tsel;

    always #5 clk = ~clk;

    str_arb #(
        .VW (VW),
        .N  (N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tlast  (s_tlast),
        .s_tvalue (s_tvalue),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .m_tvalue (m_tvalue),
        .m_tsel   (m_tsel)
    );

    int errors = 0;
    int checks = 0;

    logic [VW:0]   src_q [N][$];  // {last, value} per source
    logic [EW-1:0] exp_q [$];     // {sel, last, value}
    logic [N-1:0]  en;
    bit            sb_mode = 1'b0;

    // Values sampled on the falling edge of the cycle just completed.
    logic [N-1:0]  acc;
    logic [N-1:0]  rdy_s;
    logic          mv_s;
    logic          oxf;
    logic          o_last;
    logic [VW-1:0] o_val;
    logic [SW-1:0] o_sel;

    task automatic present();
        for (int i = 0; i < N; i++) begin
            if (en[i] && src_q[i].size() > 0) begin
                s_tvalid[i]           = 1'b1;
                s_tlast[i]            = src_q[i][0][VW];
                s_tvalue[i*VW +: VW]  = src_q[i][0][VW-1:0];
            end else begin
                s_tvalid[i]           = 1'b0;
                s_tlast[i]            = 1'b0;
                s_tvalue[i*VW +: VW]  = '0;
            end
        end
    endtask

    task automatic tick();
        logic [VW:0] b;
        @(negedge clk);
        acc    = s_tvalid & s_tready;
        rdy_s  = s_tready;
        mv_s   = m_tvalid;
        oxf    = m_tvalid && m_tready;
        o_last = m_tlast;
        o_val  = m_tvalue;
        o_sel  = m_tsel;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && src_q[i].size() > 0) begin
                b = src_q[i].pop_front();
                if (sb_mode) exp_q.push_back({SW'(i), b[VW], b[VW-1:0]});
            end
        end
        present();
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        m_tready = 1'b1;
        s_tvalid = '1;
        s_tlast  = '1;
        s_tvalue = {N{32'hDEAD_BEEF}};
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++; $display("FAIL reset_m_tvalid got=%b exp=0", m_tvalid);
        end
        checks++;
        if (m_tlast !== 1'b0) begin
            errors++; $display("FAIL reset_m_tlast got=%b exp=0", m_tlast);
        end
        checks++;
        if (m_tvalue !== '0) begin
            errors++; $display("FAIL reset_m_tvalue got=%h exp=0", m_tvalue);
        end
        checks++;
        if (m_tsel !== '0) begin
            errors++; $display("FAIL reset_m_tsel got=%0d exp=0", m_tsel);
        end
        checks++;
        if (s_tready !== '0) begin
            errors++; $display("FAIL reset_s_tready got=%b exp=0000", s_tready);
        end
        en = '0;
        present();
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [EW-1:0] e;
        int started = 0;
        int idle    = 0;
        int budget  = 0;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 2; k++) src_q[i].push_back({1'b1, VW'(32'h100 * i + k)});
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) exp_q.push_back({SW'(i), 1'b1, VW'(32'h100 * i + k)});
        en       = '1;
        m_tready = 1'b1;
        present();
        while (exp_q.size() > 0 && budget < 40) begin
            tick();
            budget++;
            if (oxf) begin
                started = 1;
                e = exp_q.pop_front();
                checks++;
                if ({o_sel, o_last, o_val} !== e) begin
                    errors++; $display("FAIL rr_beat got=%h exp=%h", {o_sel, o_last, o_val}, e);
                end
            end else if (started != 0) begin
                idle++;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rr_timeout got=%0d left exp=0", exp_q.size());
        end
        checks++;
        if (idle != 0) begin
            errors++; $display("FAIL rr_idle got=%0d exp=0", idle);
        end
        exp_q.delete();
    endtask

    task automatic test_packet();
        logic [EW-1:0] e;
        bit            open;
        int            budget = 0;
        src_q[2].push_back({1'b0, 32'hA0});
        src_q[2].push_back({1'b0, 32'hA1});
        src_q[2].push_back({1'b1, 32'hA2});
        src_q[1].push_back({1'b1, 32'hB1});
        exp_q.push_back({2'd2, 1'b0, 32'hA0});
        exp_q.push_back({2'd2, 1'b0, 32'hA1});
        exp_q.push_back({2'd2, 1'b1, 32'hA2});
        exp_q.push_back({2'd1, 1'b1, 32'hB1});
        en = 4'b0100;
        present();
        tick();
        checks++;
        if (acc !== 4'b0100) begin
            errors++; $display("FAIL pkt_first_accept got=%b exp=0100", acc);
        end
        en = 4'b0110;
        present();
        while (exp_q.size() > 0 && budget < 20) begin
            open = src_q[2].size() > 0;
            tick();
            budget++;
            if (open) begin
                checks++;
                if (rdy_s[1] !== 1'b0) begin
                    errors++; $display("FAIL pkt_s1_ready got=%b exp=0", rdy_s[1]);
                end
            end
            if (oxf) begin
                e = exp_q.pop_front();
                checks++;
                if ({o_sel, o_last, o_val} !== e) begin
                    errors++; $display("FAIL pkt_beat got=%h exp=%h", {o_sel, o_last, o_val}, e);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL pkt_timeout got=%0d left exp=0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_stall();
        src_q[0].push_back({1'b1, 32'h55});
        src_q[0].push_back({1'b1, 32'h66});
        en       = 4'b0001;
        m_tready = 1'b0;
        present();
        tick();
        checks++;
        if (acc !== 4'b0001) begin
            errors++; $display("FAIL stall_load got=%b exp=0001", acc);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if ({mv_s, o_val, rdy_s} !== {1'b1, 32'h55, 4'b0000}) begin
                errors++;
                $display("FAIL stall_hold got=v%b val=%h rdy=%b exp=v1 val=55 rdy=0000",
                         mv_s, o_val, rdy_s);
            end
        end
        m_tready = 1'b1;
        tick();
        checks++;
        if ({oxf, o_val, acc} !== {1'b1, 32'h55, 4'b0001}) begin
            errors++;
            $display("FAIL stall_release got=x%b val=%h acc=%b exp=x1 val=55 acc=0001",
                     oxf, o_val, acc);
        end
        tick();
        checks++;
        if ({oxf, o_val} !== {1'b1, 32'h66}) begin
            errors++; $display("FAIL stall_next got=x%b val=%h exp=x1 val=66", oxf, o_val);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [EW-1:0] e;
        int started = 0;
        int idle    = 0;
        int budget  = 0;
        for (int k = 0; k < 8; k++) begin
            src_q[3].push_back({1'b1, VW'(32'h300 + k)});
            exp_q.push_back({2'd3, 1'b1, VW'(32'h300 + k)});
        end
        en = 4'b1000;
        present();
        while (exp_q.size() > 0 && budget < 30) begin
            tick();
            budget++;
            if (oxf) begin
                started = 1;
                e = exp_q.pop_front();
                checks++;
                if ({o_sel, o_last, o_val} !== e) begin
                    errors++; $display("FAIL b2b_beat got=%h exp=%h", {o_sel, o_last, o_val}, e);
                end
            end else if (started != 0) begin
                idle++;
            end
        end
        checks++;
        if (exp_q.size() != 0 || idle != 0) begin
            errors++; $display("FAIL b2b_flow got=left%0d idle%0d exp=0 0", exp_q.size(), idle);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_packet();
        logic [EW-1:0] e;
        int budget = 0;
        src_q[1].push_back({1'b0, 32'hD0});
        src_q[1].push_back({1'b0, 32'hD1});
        src_q[1].push_back({1'b1, 32'hD2});
        en = 4'b0010;
        present();
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_m_tvalid got=%b exp=0", m_tvalid);
        end
        checks++;
        if (s_tready !== '0) begin
            errors++; $display("FAIL rst_mid_s_tready got=%b exp=0000", s_tready);
        end
        for (int i = 0; i < N; i++) src_q[i].delete();
        en = '0;
        present();
        @(posedge clk);
        #1;
        rst = 1'b0;
        src_q[0].push_back({1'b1, 32'hC0});
        src_q[1].push_back({1'b1, 32'hC1});
        exp_q.push_back({2'd0, 1'b1, 32'hC0});
        exp_q.push_back({2'd1, 1'b1, 32'hC1});
        en = 4'b0011;
        present();
        while (exp_q.size() > 0 && budget < 20) begin
            tick();
            budget++;
            if (oxf) begin
                e = exp_q.pop_front();
                checks++;
                if ({o_sel, o_last, o_val} !== e) begin
                    errors++;
                    $display("FAIL rst_mid_after got=%h exp=%h", {o_sel, o_last, o_val}, e);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rst_mid_timeout got=%0d left exp=0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        logic [EW-1:0] e;
        int  next_seq [N];
        int  total   = 0;
        int  out_cnt = 0;
        int  budget  = 0;
        int  len;
        bit  open     = 1'b0;
        logic [SW-1:0] open_src = '0;
        sb_mode = 1'b1;
        for (int i = 0; i < N; i++) begin
            int seq = 0;
            next_seq[i] = 0;
            for (int p = 0; p < int'($urandom_range(3, 6)); p++) begin
                len = int'($urandom_range(1, 4));
                for (int b = 0; b < len; b++) begin
                    src_q[i].push_back({b == len - 1, 4'(i), 12'(p), 16'(seq)});
                    seq++;
                    total++;
                end
            end
        end
        while (budget < 3000 && (src_q[0].size() + src_q[1].size() + src_q[2].size() +
               src_q[3].size() + exp_q.size() > 0 || m_tvalid)) begin
            en       = N'($urandom);
            m_tready = ($urandom_range(0, 3) != 0);
            present();
            tick();
            budget++;
            checks++;
            if ($countones(acc) > 1) begin
                errors++; $display("FAIL rnd_multi_accept got=%b exp=onehot0", acc);
            end
            if (oxf) begin
                out_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_extra_beat got=%h exp=none", o_val);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_sel, o_last, o_val} !== e) begin
                        errors++;
                        $display("FAIL rnd_beat got=%h exp=%h", {o_sel, o_last, o_val}, e);
                    end
                end
                checks++;
                if (open && o_sel !== open_src) begin
                    errors++; $display("FAIL rnd_interleave got=%0d exp=%0d", o_sel, open_src);
                end
                checks++;
                if (int'(o_val[15:0]) != next_seq[o_sel]) begin
                    errors++;
                    $display("FAIL rnd_order got=%0d exp=%0d", o_val[15:0], next_seq[o_sel]);
                end
                next_seq[o_sel] = int'(o_val[15:0]) + 1;
                open     = !o_last;
                open_src = o_sel;
            end
        end
        checks++;
        if (out_cnt != total) begin
            errors++; $display("FAIL rnd_count got=%0d exp=%0d", out_cnt, total);
        end
        sb_mode = 1'b0;
        en      = '0;
        present();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_packet();
        test_stall();
        test_back_to_back();
        test_reset_mid_packet();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
